// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the Execute stage.
// One operand pair is accepted in IDLE, worked on for ITER cycles (shift-add
// multiply or restoring divide on magnitudes), then the signed result is
// presented for one cycle. Divide-by-zero and signed overflow finish at once.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-high; clears all state and outputs
//   clear   - synchronous flush; aborts any operation, zeroes outputs
//   start   - M-type instruction present in Execute
//   funct3  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   SrcAE   - rs1 operand
//   SrcBE   - rs2 operand
//   RdE     - destination register
//   ResultE - result, valid while DoneE=1
//   RdOutE  - destination latched at start
//   DoneE   - one-cycle result-valid pulse
//   StallE  - stall request to the hazard unit (combinational)

module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [4:0]      RdE,
    output logic [XLEN-1:0] ResultE,
    output logic [4:0]      RdOutE,
    output logic            DoneE,
    output logic            StallE
);

    localparam int CW = $clog2(ITER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [2:0]        op_q,    op_d;
    logic [4:0]        rd_q,    rd_d;
    logic              neg_q,   neg_d;
    // a_q: multiplicand (shifted left) or dividend/quotient (low half)
    logic [2*XLEN-1:0] a_q,     a_d;
    // b_q: multiplier (shifted right) or divisor
    logic [XLEN-1:0]   b_q,     b_d;
    // acc_q: product accumulator or partial remainder (low half)
    logic [2*XLEN-1:0] acc_q,   acc_d;
    logic [XLEN-1:0]   res_q,   res_d;
    logic              done_q,  done_d;

    // ---------------------------------------------------------------
    // Operand decode at start
    // ---------------------------------------------------------------
    logic            is_div_s;
    logic            a_sgn_s;
    logic            b_sgn_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic            sign_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic            special_s;
    logic [XLEN-1:0] special_res_s;

    always_comb begin : decode
        is_div_s = funct3[2];
        // MUL/MULH/MULHSU take A signed; only MULH and MUL take B signed.
        // DIV/REM are signed, DIVU/REMU unsigned.
        if (is_div_s) begin
            a_sgn_s = ~funct3[0];
            b_sgn_s = ~funct3[0];
        end else begin
            a_sgn_s = (funct3[1:0] != 2'b11);
            b_sgn_s = ~funct3[1];
        end
        a_neg_s = a_sgn_s & SrcAE[XLEN-1];
        b_neg_s = b_sgn_s & SrcBE[XLEN-1];
        a_mag_s = a_neg_s ? (~SrcAE + 1'b1) : SrcAE;
        b_mag_s = b_neg_s ? (~SrcBE + 1'b1) : SrcBE;
        // Remainder takes the dividend's sign; everything else is XOR.
        if (is_div_s && funct3[1]) begin
            sign_s = a_neg_s;
        end else begin
            sign_s = a_neg_s ^ b_neg_s;
        end
        div_zero_s = is_div_s && (SrcBE == '0);
        ovf_s      = is_div_s && !funct3[0]
                     && (SrcAE == INT_MIN) && (SrcBE == '1);
        special_s  = div_zero_s | ovf_s;
        if (div_zero_s) begin
            special_res_s = funct3[1] ? SrcAE : '1;
        end else begin
            special_res_s = funct3[1] ? '0 : INT_MIN;
        end
    end

    // ---------------------------------------------------------------
    // One iteration of the datapath
    // ---------------------------------------------------------------
    logic [XLEN:0]     rem_sh;
    logic              qbit;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] a_it;
    logic [XLEN-1:0]   b_it;
    logic [2*XLEN-1:0] acc_it;

    always_comb begin : iterate
        // Restoring divide: shift the next dividend bit into the remainder
        // and keep the subtraction only when it does not borrow.
        rem_sh  = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        qbit    = (rem_sh >= {1'b0, b_q});
        rem_new = qbit ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0];
        if (op_q[2]) begin
            acc_it = {{XLEN{1'b0}}, rem_new};
            a_it   = {{XLEN{1'b0}}, a_q[XLEN-2:0], qbit};
            b_it   = b_q;
        end else begin
            acc_it = acc_q + (b_q[0] ? a_q : '0);
            a_it   = a_q << 1;
            b_it   = b_q >> 1;
        end
    end

    // ---------------------------------------------------------------
    // Final signed result, formed from the last iteration's values
    // ---------------------------------------------------------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_rem;
    logic [XLEN-1:0]   final_res;

    always_comb begin : finish
        prod    = neg_q ? (~acc_it + 1'b1) : acc_it;
        quo_rem = op_q[1] ? acc_it[XLEN-1:0] : a_it[XLEN-1:0];
        if (op_q[2]) begin
            final_res = neg_q ? (~quo_rem + 1'b1) : quo_rem;
        end else if (op_q[1:0] == 2'b00) begin
            final_res = prod[XLEN-1:0];
        end else begin
            final_res = prod[2*XLEN-1:XLEN];
        end
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_comb begin : control
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        neg_d   = neg_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        done_d  = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rd_d    = '0;
            res_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d  = funct3;
                        rd_d  = RdE;
                        neg_d = sign_s;
                        a_d   = {{XLEN{1'b0}}, a_mag_s};
                        b_d   = b_mag_s;
                        acc_d = '0;
                        cnt_d = CW'(ITER);
                        if (special_s) begin
                            state_d = S_DONE;
                            res_d   = special_res_s;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    a_d   = a_it;
                    b_d   = b_it;
                    acc_d = acc_it;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                        res_d   = final_res;
                        done_d  = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign ResultE = res_q;
    assign RdOutE  = rd_q;
    assign DoneE   = done_q;
    assign StallE  = ((state_q == S_IDLE) && start) || (state_q == S_CALC);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed RV32M vectors, random operations
// against a plain-arithmetic reference model, flush and reset aborts.

module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [4:0]  RdE;
    logic [31:0] ResultE;
    logic [4:0]  RdOutE;
    logic        DoneE;
    logic        StallE;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .start  (start),
        .funct3 (funct3),
        .SrcAE  (SrcAE),
        .SrcBE  (SrcBE),
        .RdE    (RdE),
        .ResultE(ResultE),
        .RdOutE (RdOutE),
        .DoneE  (DoneE),
        .StallE (StallE)
    );

    // Reference model: RV32M semantics via 64-bit host arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb);
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit ref_special(input logic [2:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Drives one operation and measures it; comparisons are done by callers.
    // lat counts rising edges from the start edge until DoneE is seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input bit scramble,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int stalls,
                          output bit stall_done, output bit done_next,
                          output bit timed_out);
        @(posedge clk); #1;
        start = 1'b1; funct3 = op; SrcAE = a; SrcBE = b; RdE = rd;
        lat = 0; stalls = 0; timed_out = 1'b1;
        res = '0; rdo = '0; stall_done = 1'b0; done_next = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (DoneE) begin
                res = ResultE; rdo = RdOutE; stall_done = StallE;
                timed_out = 1'b0;
                break;
            end
            if (StallE) stalls++;
            @(posedge clk); lat++; #1;
            if (scramble) begin
                funct3 = 3'($urandom); SrcAE = $urandom;
                SrcBE = $urandom; RdE = 5'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(posedge clk); #2;
        done_next = DoneE;
    endtask

    task automatic check_op(input string name, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] exp,
                            input bit scramble);
        logic [31:0] res;
        logic [4:0] rdo;
        int lat, stalls, exp_lat;
        bit sd, dn, to;
        run_op(op, a, b, rd, scramble, res, rdo, lat, stalls, sd, dn, to);
        exp_lat = ref_special(op, a, b) ? 1 : 33;
        checks++;
        if (to) begin
            failures++;
            $display("FAIL %s timeout: no DoneE within 100 cycles", name);
            return;
        end
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL %s result: got %h expected %h", name, res, exp);
        end
        checks++;
        if (rdo !== rd) begin
            failures++;
            $display("FAIL %s rd: got %0d expected %0d", name, rdo, rd);
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (stalls != exp_lat) begin
            failures++;
            $display("FAIL %s stall cycles: got %0d expected %0d",
                     name, stalls, exp_lat);
        end
        checks++;
        if (sd !== 1'b0) begin
            failures++;
            $display("FAIL %s stall in done: got %b expected 0", name, sd);
        end
        checks++;
        if (dn !== 1'b0) begin
            failures++;
            $display("FAIL %s done width: DoneE got %b expected 0", name, dn);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; start = 1'b0;
        funct3 = '0; SrcAE = '0; SrcBE = '0; RdE = '0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; #1;
        checks++;
        if ({ResultE, RdOutE, DoneE, StallE} !== 39'd0) begin
            failures++;
            $display("FAIL reset outputs: got res=%h rd=%0d done=%b stall=%b expected all 0",
                     ResultE, RdOutE, DoneE, StallE);
        end
    endtask

    logic [2:0]  v_op  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6,
                                3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] v_a   [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'hFFFFFFEC, 32'hFFFFFFEC,
                                32'd100, 32'd100, 32'd5, 32'd5,
                                32'h80000000, 32'h80000000};
    logic [31:0] v_b   [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd2, 32'd3, 32'd3, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] v_exp [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000,
                                32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE,
                                32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                                32'h80000000, 32'd0};

    task automatic test_directed();
        for (int i = 0; i < 12; i++) begin
            check_op($sformatf("vec%0d", i), v_op[i], v_a[i], v_b[i],
                     (i == 0) ? 5'd5 : 5'(i + 1), v_exp[i], 1'b0);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        int sel;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
            if (sel == 3) b = 32'($urandom_range(1, 15)) * 32'hFFFFFFFF;
            check_op($sformatf("rand%0d op%0d", i, op), op, a, b,
                     5'($urandom), ref_res(op, a, b), 1'b0);
        end
    endtask

    task automatic test_clear();
        bit seen;
        check_op("pre_clear divu", 3'd5, 32'd50, 32'd7, 5'd3, 32'd7, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd7; RdE = 5'd9;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0; #1;
        checks++;
        if (StallE !== 1'b0 || DoneE !== 1'b0) begin
            failures++;
            $display("FAIL clear ctrl: got stall=%b done=%b expected 0 0",
                     StallE, DoneE);
        end
        checks++;
        if (ResultE !== 32'd0 || RdOutE !== 5'd0) begin
            failures++;
            $display("FAIL clear outputs: got res=%h rd=%0d expected 0 0",
                     ResultE, RdOutE);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (DoneE) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL clear no_done: got DoneE pulse expected none");
        end
        check_op("post_clear divu", 3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; SrcAE = 32'd123456; SrcBE = 32'd789; RdE = 5'd17;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; #1;
        checks++;
        if ({ResultE, RdOutE, DoneE, StallE} !== 39'd0) begin
            failures++;
            $display("FAIL reset_mid outputs: got res=%h rd=%0d done=%b stall=%b expected all 0",
                     ResultE, RdOutE, DoneE, StallE);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (DoneE) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_mid no_done: got DoneE pulse expected none");
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] a, b;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            check_op($sformatf("busy_start mul%0d", i), 3'd1, a, b,
                     5'(12 + i), ref_res(3'd1, a, b), 1'b1);
        end
        check_op("busy_start div", 3'd4, 32'hFFFFFF00, 32'd13, 5'd21,
                 ref_res(3'd4, 32'hFFFFFF00, 32'd13), 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_clear();
        test_reset_mid();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit for the RV32M extension, located in the Execute stage beside the ALU.
- Consumes operands and the destination register from the Decode/Execute pipeline register.
- Drives a stall request to the hazard unit until its result is ready.
- Returns a 32-bit result and destination register for the Execute/Memory register to capture.

Parameters:
- XLEN, 32, operand/result width.
- ITER, 32, iterations per non-trivial operation (equals XLEN).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state and outputs.
- clear  input  1  synchronous flush (branch/exception); aborts any operation.
- start  input  1  M-type instruction present in Execute.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  input  32  rs1 operand (forwarded).
- SrcBE  input  32  rs2 operand (forwarded).
- RdE  input  5  destination register.
- ResultE  output  32  result; valid while DoneE=1.
- RdOutE  output  5  destination latched at start.
- DoneE  output  1  one-cycle result-valid pulse.
- StallE  output  1  combinational; equals (state==IDLE & start) | (state==CALC).

Behaviour:
- Reset values: ResultE=0, RdOutE=0, DoneE=0, state IDLE, counter 0, internal registers 0.
- States and transitions:
  - IDLE → CALC: start=1 and no special case.
  - IDLE → DONE: start=1 and special case.
  - CALC → DONE: after the ITER-th iteration.
  - DONE → IDLE: always (unconditional).
- Start capture (edge E0, start=1 in IDLE): latch funct3, RdE, operand magnitudes, result sign, counter=ITER.
- Normal latency: iterations occur on edges E1..E32. DoneE=1 in the cycle after E32, for exactly one cycle.
- Special-case latency: DoneE=1 in the cycle after E0.
- StallE is low in DONE, so the pipeline advances and captures ResultE.
- Start while in CALC or DONE is ignored; operands are not resampled.
- Multiply:
  - Unsigned shift-add over 32 iterations into a 64-bit product, using magnitudes.
  - Signedness: MUL/MULH treat both operands signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - Negate the 64-bit product (two's complement) if the result sign is set.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring, one quotient bit per iteration, on magnitudes.
  - Signed ops: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Special cases (single cycle, no CALC):
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → SrcAE.
  - Signed overflow (SrcAE=0x80000000, SrcBE=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - Multiply has no special cases.
- clear=1 in any state: next state IDLE, DoneE=0, ResultE/RdOutE=0. clear has priority over start in the same cycle.
- reset has priority over clear.
- reset or clear mid-CALC discards partial work; a new start is accepted the cycle after returning to IDLE.
- All arithmetic is modulo 2^64 internally; no exceptions are raised.

Test Plan:
- MUL 7 × −3 (SrcA=0x00000007, SrcB=0xFFFFFFFD), RdE=5 → StallE high 33 cycles from start; DoneE pulses after E32; ResultE=0xFFFFFFEB, RdOutE=5.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → ResultE=0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −20/3 → 0xFFFFFFFA. REM −20/3 → 0xFFFFFFFE. DIVU 100/7 → 14. REMU 100/7 → 2. Each returns DoneE after 32 iterations.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM same operands → 0. In all four, DoneE=1 in the cycle after the start edge.
- Start DIVU, assert clear at iteration 10 → StallE low next cycle, no DoneE pulse, ResultE=0. A subsequent DIVU 9/3 completes normally with 3.
- Assert reset at iteration 20 of MUL → all outputs 0 next cycle. A start asserted during CALC (with no flush) is ignored, and the original result is unchanged.
